// File: rtl/knight_decode.sv
// knight_decode: locks onto a one-hot bouncing LED sweep, tracks lamp and direction.
// Define KNIGHT_DECODE_HOLD_EN to accept a repeated lamp while locked as a dwell.
module knight_decode #(
   parameter int N  = 8,
   parameter int PW = 3,
   parameter int CW = 8
) (
   input  logic          ck,
   input  logic          res,
   input  logic          stb,
   input  logic [N-1:0]  led,
   output logic [PW-1:0] pos,
   output logic          up,
   output logic          locked,
   output logic          err,
   output logic [CW-1:0] sweep_cnt,
   output logic [CW-1:0] err_cnt
);

   typedef enum logic [1:0] {SYNC0, SYNC1, LOCK} state_t;

   localparam logic [PW-1:0] LAST = PW'(N - 1);
   localparam logic [PW-1:0] STEP = PW'(1);
   localparam logic [PW:0]   ONE  = (PW + 1)'(1);
   localparam logic [CW-1:0] INC  = CW'(1);

   state_t        state, state_n;
   logic [PW-1:0] cand, cand_n, pos_n, idx, expct;
   logic          up_n, locked_n, err_n;
   logic          onehot, adjacent;
   logic [PW:0]   hot;
   logic [CW-1:0] sweep_n, errc_n;

   always_comb begin
      hot = '0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (led[i]) begin
            hot = hot + ONE;
            idx = PW'(i);
         end
      end
   end

   // widened compare so that lamp 0 and lamp 2**PW-1 are not adjacent
   assign onehot   = (hot == ONE);
   assign adjacent = ({1'b0, idx} == {1'b0, cand} + ONE) ||
                     ({1'b0, cand} == {1'b0, idx} + ONE);
   assign expct    = up ? pos + STEP : pos - STEP;

   function automatic logic dir(input logic [PW-1:0] nw,
                                input logic [PW-1:0] prev);
      if (nw == LAST) return 1'b0;
      if (nw == '0) return 1'b1;
      return nw > prev;
   endfunction

   always_comb begin
      state_n  = state;
      cand_n   = cand;
      pos_n    = pos;
      up_n     = up;
      locked_n = locked;
      err_n    = 1'b0;
      sweep_n  = sweep_cnt;
      errc_n   = err_cnt;
      if (stb) begin
         unique case (state)
            SYNC0: begin
               if (onehot) begin
                  cand_n  = idx;
                  state_n = SYNC1;
               end
            end
            SYNC1: begin
               if (!onehot) begin
                  state_n = SYNC0;
               end else if (adjacent) begin
                  pos_n    = idx;
                  up_n     = dir(idx, cand);
                  locked_n = 1'b1;
                  state_n  = LOCK;
               end else begin
                  cand_n = idx;
               end
            end
            LOCK: begin
               if (onehot && idx == expct) begin
                  pos_n = expct;
                  up_n  = dir(expct, pos);
                  if (expct == '0) sweep_n = sweep_cnt + INC;
               end
`ifdef KNIGHT_DECODE_HOLD_EN
               else if (onehot && idx == pos) begin
                  state_n = LOCK;
               end
`endif
               else begin
                  err_n    = 1'b1;
                  locked_n = 1'b0;
                  if (err_cnt != '1) errc_n = err_cnt + INC;
                  if (onehot) begin
                     cand_n  = idx;
                     state_n = SYNC1;
                  end else begin
                     state_n = SYNC0;
                  end
               end
            end
            default: state_n = SYNC0;
         endcase
      end
   end

   always_ff @(posedge ck) begin
      if (res) begin
         state     <= SYNC0;
         cand      <= '0;
         pos       <= '0;
         up        <= 1'b1;
         locked    <= 1'b0;
         err       <= 1'b0;
         sweep_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         pos       <= pos_n;
         up        <= up_n;
         locked    <= locked_n;
         err       <= err_n;
         sweep_cnt <= sweep_n;
         err_cnt   <= errc_n;
      end
   end

endmodule

// File: tb/tb_knight_decode.sv
// tb_knight_decode: directed and random sweeps against a lamp-level reference model.
// Two instances run side by side: default counters and 2-bit counters.
module tb_knight_decode;

   logic       ck = 1'b0;
   logic       res = 1'b1;
   logic       stb = 1'b0;
   logic [7:0] led = '0;

   logic [2:0] pos1, pos2;
   logic       up1, up2, lk1, lk2, er1, er2;
   logic [7:0] sw1, ec1;
   logic [1:0] sw2, ec2;

   int total = 0;
   int bad = 0;

   always #5 ck = ~ck;

   knight_decode u1 (
      .ck(ck), .res(res), .stb(stb), .led(led),
      .pos(pos1), .up(up1), .locked(lk1), .err(er1),
      .sweep_cnt(sw1), .err_cnt(ec1)
   );

   knight_decode #(.N(8), .PW(3), .CW(2)) u2 (
      .ck(ck), .res(res), .stb(stb), .led(led),
      .pos(pos2), .up(up2), .locked(lk2), .err(er2),
      .sweep_cnt(sw2), .err_cnt(ec2)
   );

   // reference: mode 0 = searching, 1 = have one lamp, 2 = tracking
   int m_mode, m_cand, m_pos, m_sweeps, m_errs;
   bit m_up, m_lock, m_err;

   function automatic bit turn(input int nw, input int prev);
      if (nw == 7) return 1'b0;
      if (nw == 0) return 1'b1;
      return nw > prev;
   endfunction

   function automatic int lamp(input logic [7:0] v);
      int k = 0;
      for (int i = 0; i < 8; i++) if (v[i]) k = i;
      return k;
   endfunction

   task automatic model(input logic r, input logic s, input logic [7:0] l);
      bit oh;
      int k, d;
      m_err = 1'b0;
      if (r) begin
         m_mode = 0; m_cand = 0; m_pos = 0; m_up = 1'b1;
         m_lock = 1'b0; m_sweeps = 0; m_errs = 0;
      end else if (s) begin
         oh = ($countones(l) == 1);
         k = lamp(l);
         if (m_mode == 0) begin
            if (oh) begin m_cand = k; m_mode = 1; end
         end else if (m_mode == 1) begin
            d = k - m_cand;
            if (!oh) m_mode = 0;
            else if (d == 1 || d == -1) begin
               m_up = turn(k, m_cand); m_pos = k;
               m_lock = 1'b1; m_mode = 2;
            end else m_cand = k;
         end else begin
            d = m_up ? m_pos + 1 : m_pos - 1;
            if (oh && k == d) begin
               m_up = turn(k, m_pos); m_pos = k;
               if (k == 0) m_sweeps++;
            end
`ifdef KNIGHT_DECODE_HOLD_EN
            else if (oh && k == m_pos) begin
            end
`endif
            else begin
               m_err = 1'b1; m_errs++; m_lock = 1'b0;
               if (oh) begin m_cand = k; m_mode = 1; end
               else m_mode = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check();
      chk("pos", int'(pos1), m_pos);
      chk("up", int'(up1), int'(m_up));
      chk("locked", int'(lk1), int'(m_lock));
      chk("err", int'(er1), int'(m_err));
      chk("sweep_cnt", int'(sw1), m_sweeps % 256);
      chk("err_cnt", int'(ec1), m_errs > 255 ? 255 : m_errs);
      chk("pos_cw2", int'(pos2), m_pos);
      chk("up_cw2", int'(up2), int'(m_up));
      chk("locked_cw2", int'(lk2), int'(m_lock));
      chk("err_cw2", int'(er2), int'(m_err));
      chk("sweep_cnt_cw2", int'(sw2), m_sweeps % 4);
      chk("err_cnt_cw2", int'(ec2), m_errs > 3 ? 3 : m_errs);
   endtask

   task automatic step(input logic r, input logic s, input logic [7:0] l);
      @(negedge ck);
      res = r; stb = s; led = l;
      @(posedge ck);
      model(r, s, l);
      #1;
      check();
   endtask

   task automatic lit(input int k);
      logic [7:0] v;
      v = 8'h01 << k;
      step(1'b0, 1'b1, v);
   endtask

   task automatic round_trip();
      for (int i = 1; i < 8; i++) lit(i);
      for (int i = 6; i >= 0; i--) lit(i);
   endtask

   initial begin
      int g, r;
      bit gd;
      logic [7:0] rv;

      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hff);

      lit(0);
      round_trip();

      lit(1); lit(2); lit(3);
      step(1'b0, 1'b1, 8'h20);
      lit(6);

      lit(7);
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h18);

      lit(0); lit(1); lit(2); lit(3); lit(4);
      for (int i = 0; i < 10; i++) begin
         rv = 8'($urandom);
         step(1'b0, 1'b0, rv);
      end

      lit(5); lit(6); lit(7); lit(6); lit(5);
      lit(4); lit(3); lit(2);
      lit(2);

      lit(1); lit(0);
      for (int i = 0; i < 5; i++) round_trip();

      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 8'h00);
         lit(0); lit(1);
      end

      lit(2); lit(3);
      step(1'b1, 1'b1, 8'h10);
      step(1'b0, 1'b1, 8'h01);

      g = 0; gd = 1'b1;
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 99));
         rv = 8'($urandom);
         if (r < 2) begin
            step(1'b1, rv[0], rv);
         end else if (r < 8) begin
            step(1'b0, 1'b0, rv);
         end else if (r < 13) begin
            step(1'b0, 1'b1, rv);
         end else if (r < 16) begin
            lit(g);
         end else begin
            if (gd && g == 7) gd = 1'b0;
            else if (!gd && g == 0) gd = 1'b1;
            g = gd ? g + 1 : g - 1;
            lit(g);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
